// File: rtl/multicycle_ctrl.sv
// Multi-cycle main controller: FETCH/DECODE/EXEC/WB sequencing, retire counter and illegal-op trap.
// Optional fetch watchdog enabled by defining MC_CTRL_FETCH_TIMEOUT_EN.
module multicycle_ctrl #(
  parameter int RETIRE_W      = 16,
  parameter int FETCH_TIMEOUT = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [5:0]          instr_op_i,
  input  logic                imem_ack_i,
  output logic                imem_req_o,
  output logic                ir_write_o,
  output logic                pc_write_o,
  output logic                reg_write_o,
  output logic                alu_src_o,
  output logic                reg_dst_o,
  output logic                branch_o,
  output logic [2:0]          alu_op_o,
  output logic [2:0]          state_o,
  output logic                illegal_o,
  output logic [RETIRE_W-1:0] retire_cnt_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  typedef struct packed {
    logic [2:0] alu_op;
    logic       alu_src;
    logic       reg_dst;
    logic       branch;
  } ctrl_t;

  state_t              state;
  logic [5:0]          op_q;
  logic [RETIRE_W-1:0] retire_cnt;
  logic                imem_req;
  logic                reg_write;
  logic                alu_src;
  logic                reg_dst;
  logic                branch;
  logic [2:0]          alu_op;
  logic                illegal;
  logic                fetch_expired;
  ctrl_t               exec_ctrl;

  function automatic logic op_legal(input logic [5:0] op);
    case (op)
      6'd0, 6'd4, 6'd8, 6'd10: op_legal = 1'b1;
      default:                 op_legal = 1'b0;
    endcase
  endfunction

  function automatic ctrl_t decode_ctrl(input logic [5:0] op);
    ctrl_t c;
    case (op)
      6'd0:    c = '{alu_op: 3'b010, alu_src: 1'b0, reg_dst: 1'b1, branch: 1'b0};
      6'd8:    c = '{alu_op: 3'b110, alu_src: 1'b1, reg_dst: 1'b0, branch: 1'b0};
      6'd10:   c = '{alu_op: 3'b111, alu_src: 1'b1, reg_dst: 1'b0, branch: 1'b0};
      6'd4:    c = '{alu_op: 3'b001, alu_src: 1'b0, reg_dst: 1'b0, branch: 1'b1};
      default: c = '{alu_op: 3'b000, alu_src: 1'b0, reg_dst: 1'b0, branch: 1'b0};
    endcase
    return c;
  endfunction

  assign exec_ctrl = decode_ctrl(op_q);

`ifdef MC_CTRL_FETCH_TIMEOUT_EN
  localparam int WAIT_W = $clog2(FETCH_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(FETCH_TIMEOUT - 1);

  logic [WAIT_W-1:0] wait_cnt;

  // Count un-acked FETCH cycles; anything outside FETCH rearms the counter.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wait_cnt <= '0;
    end else if (state != FETCH) begin
      wait_cnt <= '0;
    end else if (!imem_ack_i) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end else begin
      wait_cnt <= wait_cnt;
    end
  end

  // This cycle is the last allowed wait; an ack arriving now still takes priority.
  assign fetch_expired = (state == FETCH) && !imem_ack_i && (wait_cnt == WAIT_LAST);
`else
  assign fetch_expired = 1'b0;
`endif

  // Controller FSM; outputs are registered for the state being entered.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= IDLE;
      op_q       <= 6'd0;
      retire_cnt <= '0;
      illegal    <= 1'b0;
      imem_req   <= 1'b0;
      reg_write  <= 1'b0;
      alu_src    <= 1'b0;
      reg_dst    <= 1'b0;
      branch     <= 1'b0;
      alu_op     <= 3'b000;
    end else begin
      imem_req  <= 1'b0;
      reg_write <= 1'b0;
      alu_src   <= 1'b0;
      reg_dst   <= 1'b0;
      branch    <= 1'b0;
      alu_op    <= 3'b000;
      case (state)
        IDLE: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH: begin
          if (imem_ack_i) begin
            op_q  <= instr_op_i;
            state <= DECODE;
          end else if (fetch_expired) begin
            state   <= TRAP;
            illegal <= 1'b1;
          end else begin
            state    <= FETCH;
            imem_req <= 1'b1;
          end
        end
        DECODE: begin
          if (op_legal(op_q)) begin
            state   <= EXEC;
            alu_op  <= exec_ctrl.alu_op;
            alu_src <= exec_ctrl.alu_src;
            reg_dst <= exec_ctrl.reg_dst;
            branch  <= exec_ctrl.branch;
          end else begin
            state   <= TRAP;
            illegal <= 1'b1;
          end
        end
        EXEC: begin
          if (exec_ctrl.branch) begin
            state      <= FETCH;
            imem_req   <= 1'b1;
            retire_cnt <= retire_cnt + RETIRE_W'(1);
          end else begin
            // WB keeps the ALU controls stable while the result is written.
            state     <= WB;
            reg_write <= 1'b1;
            alu_op    <= alu_op;
            alu_src   <= alu_src;
            reg_dst   <= reg_dst;
          end
        end
        WB: begin
          state      <= FETCH;
          imem_req   <= 1'b1;
          retire_cnt <= retire_cnt + RETIRE_W'(1);
        end
        TRAP: begin
          state   <= TRAP;
          illegal <= 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign ir_write_o   = (state == FETCH) && imem_ack_i;
  assign pc_write_o   = (state == FETCH) && imem_ack_i;
  assign imem_req_o   = imem_req;
  assign reg_write_o  = reg_write;
  assign alu_src_o    = alu_src;
  assign reg_dst_o    = reg_dst;
  assign branch_o     = branch;
  assign alu_op_o     = alu_op;
  assign state_o      = state;
  assign illegal_o    = illegal;
  assign retire_cnt_o = retire_cnt;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed vector table, corner-case sequences and a
// randomized instruction stream checked against a transaction-level trace model.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic [2:0] st;
    logic       req;
    logic       irw;
    logic       pcw;
    logic       rw;
    logic       asrc;
    logic       rdst;
    logic       br;
    logic [2:0] aop;
    logic       ill;
    logic [3:0] ret;
  } outs_t;

  typedef struct {
    logic       ack;
    logic [5:0] op;
    outs_t      exp;
  } vec_t;

  logic       clk_i;
  logic       rst_i;
  logic [5:0] instr_op_i;
  logic       imem_ack_i;
  logic       imem_req_o, ir_write_o, pc_write_o, reg_write_o;
  logic       alu_src_o, reg_dst_o, branch_o, illegal_o;
  logic [2:0] alu_op_o, state_o;
  logic [3:0] retire_cnt_o;

  int         checks;
  int         errors;
  vec_t       trace[$];
  vec_t       dir_tbl[17];
  logic [3:0] mret;

  multicycle_ctrl #(.RETIRE_W(4), .FETCH_TIMEOUT(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .instr_op_i(instr_op_i), .imem_ack_i(imem_ack_i),
    .imem_req_o(imem_req_o), .ir_write_o(ir_write_o), .pc_write_o(pc_write_o),
    .reg_write_o(reg_write_o), .alu_src_o(alu_src_o), .reg_dst_o(reg_dst_o),
    .branch_o(branch_o), .alu_op_o(alu_op_o), .state_o(state_o),
    .illegal_o(illegal_o), .retire_cnt_o(retire_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic vec_t mk(input logic ack, input logic [5:0] op, input logic [2:0] st,
                              input logic req, input logic irw, input logic pcw, input logic rw,
                              input logic asrc, input logic rdst, input logic br,
                              input logic [2:0] aop, input logic ill, input logic [3:0] ret);
    vec_t v;
    v.ack = ack;
    v.op  = op;
    v.exp = {st, req, irw, pcw, rw, asrc, rdst, br, aop, ill, ret};
    return v;
  endfunction

  function automatic logic legal(input logic [5:0] op);
    return (op == 6'd0) || (op == 6'd4) || (op == 6'd8) || (op == 6'd10);
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(1, 0));
  endfunction

  function automatic logic [5:0] rop();
    return 6'($urandom_range(63, 0));
  endfunction

  task automatic chk(input string nm, input outs_t e);
    outs_t a;
    a = {state_o, imem_req_o, ir_write_o, pc_write_o, reg_write_o, alu_src_o, reg_dst_o,
         branch_o, alu_op_o, illegal_o, retire_cnt_o};
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got st=%0d req=%b irw=%b pcw=%b rw=%b asrc=%b rdst=%b br=%b aop=%b ill=%b ret=%0d, expected st=%0d req=%b irw=%b pcw=%b rw=%b asrc=%b rdst=%b br=%b aop=%b ill=%b ret=%0d",
               nm, a.st, a.req, a.irw, a.pcw, a.rw, a.asrc, a.rdst, a.br, a.aop, a.ill, a.ret,
               e.st, e.req, e.irw, e.pcw, e.rw, e.asrc, e.rdst, e.br, e.aop, e.ill, e.ret);
    end
  endtask

  // Asserts reset (checked asynchronously), holds it 3 cycles, releases at a falling edge.
  task automatic start_run(input string tag);
    rst_i      = 1'b0;
    imem_ack_i = rbit();
    instr_op_i = rop();
    #1;
    chk({tag, "_reset"}, outs_t'(0));
    repeat (3) @(negedge clk_i);
    rst_i = 1'b1;
    mret  = 4'd0;
    trace.delete();
    trace.push_back(mk(rbit(), rop(), 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 4'd0));
  endtask

  task automatic run_trace(input string tag);
    for (int i = 0; i < trace.size(); i++) begin
      if (i > 0) @(negedge clk_i);
      imem_ack_i = trace[i].ack;
      instr_op_i = trace[i].op;
      #1;
      chk($sformatf("%s[%0d]", tag, i), trace[i].exp);
    end
  endtask

  // Reference model: one instruction as a list of cycles derived from the opcode table.
  task automatic add_instr(input logic [5:0] op, input int wt);
    logic [2:0] aop;
    logic       asrc, rdst;
    for (int i = 0; i < wt; i++)
      trace.push_back(mk(1'b0, rop(), 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, mret));
    trace.push_back(mk(1'b1, op, 3'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, mret));
    trace.push_back(mk(rbit(), rop(), 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, mret));
    if (legal(op)) begin
      case (op)
        6'd0:    begin aop = 3'b010; asrc = 1'b0; rdst = 1'b1; end
        6'd8:    begin aop = 3'b110; asrc = 1'b1; rdst = 1'b0; end
        6'd10:   begin aop = 3'b111; asrc = 1'b1; rdst = 1'b0; end
        default: begin aop = 3'b001; asrc = 1'b0; rdst = 1'b0; end
      endcase
      trace.push_back(mk(rbit(), rop(), 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, asrc, rdst, op == 6'd4,
                         aop, 1'b0, mret));
      if (op != 6'd4)
        trace.push_back(mk(rbit(), rop(), 3'd4, 1'b0, 1'b0, 1'b0, 1'b1, asrc, rdst, 1'b0,
                           aop, 1'b0, mret));
      mret = mret + 4'd1;
    end
  endtask

  task automatic add_fetch_idle();
    trace.push_back(mk(1'b0, rop(), 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, mret));
  endtask

  task automatic add_trap(input int n);
    for (int i = 0; i < n; i++)
      trace.push_back(mk(rbit(), rop(), 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, mret));
  endtask

  initial begin
    logic [5:0] op;
    int         n;
    checks = 0;
    errors = 0;
    rst_i  = 1'b0;
    imem_ack_i = 1'b0;
    instr_op_i = 6'd0;

    // Reset, R-type, then addi/slti/beq with ack held high.
    dir_tbl[0]  = mk(1'b0, 6'd0,  3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 4'd0);
    dir_tbl[1]  = mk(1'b1, 6'd0,  3'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 4'd0);
    dir_tbl[2]  = mk(1'b1, 6'd0,  3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 4'd0);
    dir_tbl[3]  = mk(1'b1, 6'd0,  3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b010, 1'b0, 4'd0);
    dir_tbl[4]  = mk(1'b1, 6'd0,  3'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'b010, 1'b0, 4'd0);
    dir_tbl[5]  = mk(1'b1, 6'd8,  3'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 4'd1);
    dir_tbl[6]  = mk(1'b1, 6'd8,  3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 4'd1);
    dir_tbl[7]  = mk(1'b1, 6'd8,  3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b110, 1'b0, 4'd1);
    dir_tbl[8]  = mk(1'b1, 6'd8,  3'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'b110, 1'b0, 4'd1);
    dir_tbl[9]  = mk(1'b1, 6'd10, 3'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 4'd2);
    dir_tbl[10] = mk(1'b1, 6'd10, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 4'd2);
    dir_tbl[11] = mk(1'b1, 6'd10, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b111, 1'b0, 4'd2);
    dir_tbl[12] = mk(1'b1, 6'd10, 3'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'b111, 1'b0, 4'd2);
    dir_tbl[13] = mk(1'b1, 6'd4,  3'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 4'd3);
    dir_tbl[14] = mk(1'b1, 6'd4,  3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 4'd3);
    dir_tbl[15] = mk(1'b1, 6'd4,  3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b001, 1'b0, 4'd3);
    dir_tbl[16] = mk(1'b0, 6'd4,  3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 4'd4);

    start_run("dir");
    trace.delete();
    foreach (dir_tbl[i]) trace.push_back(dir_tbl[i]);
    run_trace("dir");

    start_run("wait5");
    add_instr(6'd8, 5);
    add_fetch_idle();
    run_trace("wait5");

    start_run("illegal");
    add_instr(6'd0, 1);
    add_instr(6'd35, 0);
    add_trap(20);
    run_trace("illegal");

    start_run("wrap");
    for (int i = 0; i < 16; i++) add_instr(6'd4, i % 3);
    add_fetch_idle();
    run_trace("wrap");

    // Reset lands in the middle of a WB cycle after one retired beq.
    start_run("mid_wb");
    add_instr(6'd4, 0);
    add_instr(6'd0, 1);
    run_trace("mid_wb");
    rst_i = 1'b0;
    #1;
    chk("mid_wb_async_reset", outs_t'(0));

`ifdef MC_CTRL_FETCH_TIMEOUT_EN
    start_run("tmo");
    for (int i = 0; i < 4; i++)
      trace.push_back(mk(1'b0, rop(), 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 4'd0));
    add_trap(6);
    run_trace("tmo");

    start_run("tmo_ack");
    add_instr(6'd8, 3);
    add_fetch_idle();
    run_trace("tmo_ack");
`endif

    for (int r = 0; r < 40; r++) begin
      start_run("rnd");
      n = $urandom_range(8, 1);
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(9, 0) == 0) op = rop();
        else begin
          case ($urandom_range(3, 0))
            0:       op = 6'd0;
            1:       op = 6'd8;
            2:       op = 6'd10;
            default: op = 6'd4;
          endcase
        end
        add_instr(op, $urandom_range(3, 0));
        if (!legal(op)) break;
      end
      if (!legal(op)) add_trap(4);
      else add_fetch_idle();
      run_trace($sformatf("rnd%0d", r));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle main controller for the single-issue CPU datapath. Sequences each instruction through fetch, decode, execute and write-back states, handshakes with the instruction memory, and drives the same control signals the single-cycle opcode decoder produces, spread over multiple cycles. It also counts retired instructions and traps on unsupported opcodes. It sits between the instruction memory interface and the PC, IR, register file and ALU control.

## Interface

**Parameters**
- `RETIRE_W`, default 16: width of the retired-instruction counter.
- `FETCH_TIMEOUT`, default 16: maximum FETCH wait in cycles. Used only with `MC_CTRL_FETCH_TIMEOUT_EN`.

**Ports**
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rst_i`  in  1  reset, asynchronous, active-low.
- `instr_op_i`  in  6  opcode field of the fetched word; valid only when `imem_ack_i`=1.
- `imem_ack_i`  in  1  instruction memory has returned the word.
- `imem_req_o`  out  1  fetch request.
- `ir_write_o`  out  1  load IR (one-cycle pulse).
- `pc_write_o`  out  1  load PC+4 (one-cycle pulse).
- `reg_write_o`  out  1  register file write enable.
- `alu_src_o`  out  1  ALU B operand: 1 = immediate.
- `reg_dst_o`  out  1  destination select: 1 = rd.
- `branch_o`  out  1  conditional branch enable.
- `alu_op_o`  out  3  ALU control class.
- `state_o`  out  3  current state encoding.
- `illegal_o`  out  1  sticky trap flag.
- `retire_cnt_o`  out  RETIRE_W  count of retired instructions.

## Operation

- **State encoding:** IDLE=0, FETCH=1, DECODE=2, EXEC=3, WB=4, TRAP=5. Encodings 6 and 7 go to IDLE.
- **Reset:** state=IDLE, `op_q`=0, `retire_cnt_o`=0, `illegal_o`=0. All outputs are 0 in IDLE.
- **IDLE → FETCH** unconditionally.
- **FETCH:**
  - `imem_req_o`=1.
  - On `imem_ack_i`=1: `ir_write_o`=1 and `pc_write_o`=1 for that cycle, `instr_op_i` is latched into `op_q`, next state is DECODE.
  - Otherwise stay in FETCH.
- **DECODE:**
  - `op_q` ∈ {0, 8, 10, 4} → EXEC.
  - Any other value → TRAP.
  - No control outputs are asserted.
- **EXEC:** outputs are decoded from `op_q` only:
  - 0 (R-type): `alu_op_o`=010, `reg_dst_o`=1, `alu_src_o`=0 → WB.
  - 8 (addi): `alu_op_o`=110, `alu_src_o`=1, `reg_dst_o`=0 → WB.
  - 10 (slti): `alu_op_o`=111, `alu_src_o`=1, `reg_dst_o`=0 → WB.
  - 4 (beq): `alu_op_o`=001, `branch_o`=1 for exactly one cycle; retire counter increments; next state FETCH.
- **WB:**
  - `alu_op_o`, `alu_src_o` and `reg_dst_o` hold their EXEC values.
  - `reg_write_o`=1 for exactly one cycle.
  - Retire counter increments; next state FETCH.
- **TRAP:** `illegal_o`=1. The block stays in TRAP until reset and never requests again.
- **Retire counter:** RETIRE_W bits, wraps from all-ones to 0 with no flag.
- **Output decode:** all control outputs are decoded from the registered state and `op_q` only. They have no combinational path from `instr_op_i` or `imem_ack_i`, except `ir_write_o`/`pc_write_o`, which are FETCH AND `imem_ack_i`.

## Timing

- **Minimum latency** (ack in the first FETCH cycle):
  - R/addi/slti: 4 cycles (FETCH, DECODE, EXEC, WB).
  - beq: 3 cycles.
- **Wait states:** each cycle `imem_ack_i` is low in FETCH adds one cycle.
- **Ack outside FETCH:** ignored; no latch, no pulse.
- **Request held low during wait:** if `imem_req_o` is deasserted while the memory is still busy, behaviour is undefined. The memory must not drop its ack obligation.
- **Retire/fetch overlap:** the increment happens on the WB→FETCH (or EXEC→FETCH for beq) edge, so the counter is updated in the first cycle of the next FETCH.
- **Reset mid-instruction:** immediate return to IDLE. Outputs go to 0 asynchronously and the in-flight instruction is discarded without retiring.
- **Trap timing:** an illegal opcode reaches TRAP 2 cycles after its ack. `reg_write_o`, `branch_o` and `pc_write_o` are never asserted for it beyond the fetch pulse.

## Configuration

- **`MC_CTRL_FETCH_TIMEOUT_EN` defined:**
  - A wait counter of clog2(FETCH_TIMEOUT+1) bits clears on FETCH entry and increments each FETCH cycle without ack.
  - When it reaches FETCH_TIMEOUT with no ack, the next state is TRAP and `illegal_o`=1.
  - An ack on the cycle the count reaches FETCH_TIMEOUT wins: normal FETCH→DECODE.
- **Undefined:** no counter; FETCH waits indefinitely and `FETCH_TIMEOUT` is unused.

## Test plan

- **Reset and basic sequence:** reset low 3 cycles, release, hold ack=1 with op=0 → IDLE, FETCH, DECODE, EXEC (`alu_op_o`=010, `reg_dst_o`=1), WB (`reg_write_o`=1); `retire_cnt_o`=1 on the next cycle.
- **Instruction mix:** ack=1 with ops 8, 10, 4 in sequence → EXEC `alu_op_o` 110/`alu_src_o`=1, then 111/`alu_src_o`=1, then 001/`branch_o`=1 for one cycle; total 11 cycles after first FETCH; counter=3.
- **Fetch wait states:** ack delayed 5 cycles, op=8 → `imem_req_o` high for 6 cycles, `ir_write_o`/`pc_write_o` pulse only on the ack cycle, instruction completes 3 cycles later.
- **Illegal opcode:** op=35 with ack → TRAP two cycles later, `illegal_o`=1 held, `imem_req_o`=0 for 20 cycles; reset clears `illegal_o` and the counter.
- **Counter wrap and reset mid-op:** with RETIRE_W=4, 16 beq instructions → counter wraps to 0. Assert reset during WB → `reg_write_o` drops immediately and the counter reads 0.
- **Timeout:** with `MC_CTRL_FETCH_TIMEOUT_EN` and FETCH_TIMEOUT=4, hold ack low → TRAP after 4 FETCH cycles. Ack on the 4th cycle instead → DECODE.
